// File: rtl/kmrf_pkg.sv
// Shared types and helpers for the kernel MAC register file.
package kmrf_pkg;

    // MAC sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } mac_state_e;

    // Dedicated register indices, counted down from the top of the file
    function automatic int unsigned krow_idx(input int unsigned num_regs);
        return num_regs - 4;
    endfunction

    function automatic int unsigned pix_idx(input int unsigned num_regs);
        return num_regs - 3;
    endfunction

    function automatic int unsigned acc_idx(input int unsigned num_regs);
        return num_regs - 2;
    endfunction

    function automatic int unsigned pc_idx(input int unsigned num_regs);
        return num_regs - 1;
    endfunction

    // Signed range limits for a register of the given width
    function automatic logic signed [127:0] sat_max(input int unsigned bits);
        return (128'sd1 <<< (bits - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] sat_min(input int unsigned bits);
        return -(128'sd1 <<< (bits - 1));
    endfunction

endpackage

// File: rtl/kmrf_mac_unit.sv
// One accumulate step: acc + sext(elem) * pix, wrapped or clamped to BITS.
module kmrf_mac_unit
    import kmrf_pkg::*;
#(
    parameter int unsigned BITS     = 24,
    parameter int unsigned EW       = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic [BITS-1:0] acc_i,
    input  logic [EW-1:0]   elem_i,
    input  logic [BITS-1:0] pix_i,
    output logic [BITS-1:0] acc_o
);

    // Two guard bits above the full product so the sum never overflows internally
    localparam int unsigned SW = 2 * BITS + 2;
    localparam logic signed [SW-1:0] MaxVal = SW'(sat_max(BITS));
    localparam logic signed [SW-1:0] MinVal = SW'(sat_min(BITS));

    logic signed [SW-1:0] acc_ext;
    logic signed [SW-1:0] elem_ext;
    logic signed [SW-1:0] pix_ext;
    logic signed [SW-1:0] sum;

    // Sign-extend, multiply-add, then wrap or clamp
    always_comb begin
        acc_ext  = {{(SW - BITS){acc_i[BITS-1]}}, acc_i};
        elem_ext = {{(SW - EW){elem_i[EW-1]}}, elem_i};
        pix_ext  = {{(SW - BITS){pix_i[BITS-1]}}, pix_i};
        sum      = acc_ext + elem_ext * pix_ext;
        acc_o    = sum[BITS-1:0];
        if (SATURATE != 0) begin
            if (sum > MaxVal) begin
                acc_o = MaxVal[BITS-1:0];
            end else if (sum < MinVal) begin
                acc_o = MinVal[BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/kernel_mac_register_file.sv
// Register file with a sequential kernel-row multiply-accumulate engine.
module kernel_mac_register_file
    import kmrf_pkg::*;
#(
    parameter int unsigned BITS     = 24,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ELEMS    = 3,
    parameter int unsigned SATURATE = 0,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            WRT_ENA,
    input  logic [AW-1:0]   ADDRS_RD,
    input  logic [AW-1:0]   ADDRS_RN,
    input  logic [AW-1:0]   ADDRS_RM,
    input  logic [BITS-1:0] WRT_DATA,
    input  logic [BITS-1:0] PC_DATA,
    input  logic            MAC_START,
    output logic [BITS-1:0] RN_DATA,
    output logic [BITS-1:0] RM_DATA,
    output logic            MAC_BUSY,
    output logic            MAC_DONE
);

    localparam int unsigned EW = BITS / ELEMS;
    localparam int unsigned CW = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    localparam logic [AW-1:0] KrowIdx = AW'(krow_idx(NUM_REGS));
    localparam logic [AW-1:0] PixIdx  = AW'(pix_idx(NUM_REGS));
    localparam logic [AW-1:0] AccIdx  = AW'(acc_idx(NUM_REGS));
    localparam logic [AW-1:0] PcIdx   = AW'(pc_idx(NUM_REGS));
    localparam logic [CW-1:0] LastCnt = CW'(ELEMS - 1);

    logic [BITS-1:0] regs_q [NUM_REGS];
    logic [BITS-1:0] regs_d [NUM_REGS];

    mac_state_e      state_q;
    logic [BITS-1:0] shreg_q;
    logic [BITS-1:0] pix_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;

    logic [BITS-1:0] acc_step;
    logic            mac_active;
    logic            wr_protected;

    kmrf_mac_unit #(
        .BITS    (BITS),
        .EW      (EW),
        .SATURATE(SATURATE)
    ) u_mac_unit (
        .acc_i (regs_q[AccIdx]),
        .elem_i(shreg_q[BITS-1 -: EW]),
        .pix_i (pix_q),
        .acc_o (acc_step)
    );

    // Next register contents: PC tracking, architectural write, MAC accumulate
    always_comb begin
        regs_d        = regs_q;
        mac_active    = (state_q != StIdle);
        wr_protected  = (ADDRS_RD == KrowIdx) || (ADDRS_RD == PixIdx) || (ADDRS_RD == AccIdx);
        regs_d[PcIdx] = PC_DATA;
        // MAC operands and accumulator are owned by the engine until it returns to idle
        if (WRT_ENA && !(mac_active && wr_protected)) begin
            regs_d[ADDRS_RD] = WRT_DATA;
        end
        if (state_q == StRun) begin
            regs_d[AccIdx] = acc_step;
        end
    end

    // Register array state
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // MAC sequencer with registered busy/done
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            shreg_q <= '0;
            pix_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (MAC_START) begin
                        // Operands are captured pre-write, so a same-cycle write does not leak in
                        shreg_q <= regs_q[KrowIdx];
                        pix_q   <= regs_q[PixIdx];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    shreg_q <= shreg_q << EW;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LastCnt) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Combinational read ports, no write bypass
    always_comb begin
        RN_DATA  = regs_q[ADDRS_RN];
        RM_DATA  = regs_q[ADDRS_RM];
        MAC_BUSY = busy_q;
        MAC_DONE = done_q;
    end

endmodule

// File: tb/tb_kernel_mac_register_file.sv
// Directed and randomized bench for kernel_mac_register_file (three configurations).
module tb_kernel_mac_register_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        wen = 1'b0;
    logic [3:0]  ard = '0;
    logic [3:0]  arn = '0;
    logic [3:0]  arm = '0;
    logic [23:0] wdata = '0;
    logic [23:0] pcdata = 24'h000040;
    logic        start = 1'b0;

    logic [23:0] rn_a, rm_a, rn_s, rm_s;
    logic        busy_a, done_a, busy_s, done_s;

    logic        w_wen = 1'b0;
    logic [4:0]  w_ard = '0;
    logic [4:0]  w_arn = '0;
    logic [4:0]  w_arm = '0;
    logic [31:0] w_wdata = '0;
    logic [31:0] w_pc = '0;
    logic        w_start = 1'b0;
    logic [31:0] w_rn, w_rm;
    logic        w_busy, w_done;

    int checks = 0;
    int failures = 0;

    kernel_mac_register_file #(
        .BITS(24), .NUM_REGS(16), .ELEMS(3), .SATURATE(0)
    ) u_dut (
        .CLK(clk), .RST(rst), .WRT_ENA(wen), .ADDRS_RD(ard), .ADDRS_RN(arn), .ADDRS_RM(arm),
        .WRT_DATA(wdata), .PC_DATA(pcdata), .MAC_START(start),
        .RN_DATA(rn_a), .RM_DATA(rm_a), .MAC_BUSY(busy_a), .MAC_DONE(done_a)
    );

    kernel_mac_register_file #(
        .BITS(24), .NUM_REGS(16), .ELEMS(3), .SATURATE(1)
    ) u_sat (
        .CLK(clk), .RST(rst), .WRT_ENA(wen), .ADDRS_RD(ard), .ADDRS_RN(arn), .ADDRS_RM(arm),
        .WRT_DATA(wdata), .PC_DATA(pcdata), .MAC_START(start),
        .RN_DATA(rn_s), .RM_DATA(rm_s), .MAC_BUSY(busy_s), .MAC_DONE(done_s)
    );

    kernel_mac_register_file #(
        .BITS(32), .NUM_REGS(32), .ELEMS(4), .SATURATE(0)
    ) u_wide (
        .CLK(clk), .RST(rst), .WRT_ENA(w_wen), .ADDRS_RD(w_ard), .ADDRS_RN(w_arn),
        .ADDRS_RM(w_arm), .WRT_DATA(w_wdata), .PC_DATA(w_pc), .MAC_START(w_start),
        .RN_DATA(w_rn), .RM_DATA(w_rm), .MAC_BUSY(w_busy), .MAC_DONE(w_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [23:0] data);
        wen = 1'b1;
        ard = addr;
        wdata = data;
        step();
        wen = 1'b0;
    endtask

    task automatic wr_w(input logic [4:0] addr, input logic [31:0] data);
        w_wen = 1'b1;
        w_ard = addr;
        w_wdata = data;
        step();
        w_wen = 1'b0;
    endtask

    // Reference: three signed 8-bit elements, MSB first, each added as elem * pix
    function automatic logic [23:0] mac_ref(input logic [23:0] a, input logic [23:0] k,
                                            input logic [23:0] p, input bit sat);
        longint acc;
        longint pv;
        longint e;
        logic [7:0]  eb;
        logic [23:0] t;
        acc = longint'($signed(a));
        pv  = longint'($signed(p));
        for (int i = 2; i >= 0; i--) begin
            eb  = k[i*8 +: 8];
            e   = longint'($signed(eb));
            acc = acc + e * pv;
            if (sat) begin
                if (acc > 64'sd8388607) acc = 64'sd8388607;
                if (acc < -64'sd8388608) acc = -64'sd8388608;
            end else begin
                t   = acc[23:0];
                acc = longint'($signed(t));
            end
        end
        t = acc[23:0];
        return t;
    endfunction

    // From the current cycle, count busy cycles until done shows up (bounded)
    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (busy_a) nbusy++;
            if (done_a) seen = 1'b1;
            else step();
        end
    endtask

    // Load operands, start, and check busy length, done pulse and both ACC results
    task automatic run_mac(input string tag, input logic [23:0] k, input logic [23:0] p,
                           input logic [23:0] a);
        int  nb;
        bit  seen;
        wr(4'd12, k);
        wr(4'd13, p);
        wr(4'd14, a);
        arn = 4'd14;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(nb, seen);
        chk({tag, "_busy_cycles"}, nb, 3);
        chk({tag, "_done_seen"}, {31'd0, seen}, 1);
        chk({tag, "_busy_at_done"}, {31'd0, busy_a}, 0);
        chk({tag, "_acc_wrap"}, {8'd0, rn_a}, {8'd0, mac_ref(a, k, p, 1'b0)});
        chk({tag, "_acc_sat"}, {8'd0, rn_s}, {8'd0, mac_ref(a, k, p, 1'b1)});
        step();
        chk({tag, "_done_one_cycle"}, {31'd0, done_a}, 0);
    endtask

    initial begin
        int  nb;
        int  ndone;
        bit  seen;
        logic [23:0] k, p, a, r1;

        // Reset state
        rst = 1'b1;
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            arn = 4'(i);
            #1;
            chk("reset_reg", {8'd0, rn_a}, 0);
        end
        chk("reset_busy", {31'd0, busy_a}, 0);
        chk("reset_done", {31'd0, done_a}, 0);
        chk("reset_wide_busy", {31'd0, w_busy}, 0);
        rst = 1'b0;
        step();
        arn = 4'd15;
        #1;
        chk("pc_after_reset", {8'd0, rn_a}, 32'h40);

        // Basic MAC with per-edge checks
        wr(4'd12, 24'h01FF02);
        wr(4'd13, 24'd100);
        wr(4'd14, 24'd0);
        arn = 4'd14;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("basic_busy_t", {31'd0, busy_a}, 1);
        chk("basic_acc_t", {8'd0, rn_a}, 0);
        step();
        chk("basic_acc_1", {8'd0, rn_a}, 100);
        chk("basic_busy_1", {31'd0, busy_a}, 1);
        step();
        chk("basic_acc_2", {8'd0, rn_a}, 0);
        chk("basic_busy_2", {31'd0, busy_a}, 1);
        step();
        chk("basic_acc_3", {8'd0, rn_a}, 200);
        chk("basic_done", {31'd0, done_a}, 1);
        chk("basic_busy_done", {31'd0, busy_a}, 0);
        step();
        chk("basic_done_clear", {31'd0, done_a}, 0);

        // Overflow, both wrap and clamp
        run_mac("ovf_pos", 24'h010000, 24'h000020, 24'h7FFFF0);
        chk("ovf_pos_wrap_const", {8'd0, rn_a}, 32'h800010);
        chk("ovf_pos_sat_const", {8'd0, rn_s}, 32'h7FFFFF);
        run_mac("ovf_neg", 24'hFF0000, 24'h000010, 24'h800008);
        chk("ovf_neg_sat_const", {8'd0, rn_s}, 32'h800000);

        // All-zero kernel still takes the full cycle count
        run_mac("zero_kernel", 24'h000000, 24'h000005, 24'h000007);

        // Randomized operands
        for (int n = 0; n < 16; n++) begin
            k = 24'($urandom);
            p = (n % 2 == 0) ? 24'($urandom) : 24'($urandom_range(0, 300));
            a = 24'($urandom);
            run_mac("rand", k, p, a);
        end

        // Blocking: ACC write and restarts ignored while running, other writes proceed
        wr(4'd12, 24'h010203);
        wr(4'd13, 24'd3);
        wr(4'd14, 24'd10);
        arn = 4'd14;
        start = 1'b1;
        step();
        wen = 1'b1;
        ard = 4'd14;
        wdata = 24'h005555;
        step();
        ard = 4'd0;
        wdata = 24'h001234;
        step();
        wen = 1'b0;
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done_a) ndone++;
            step();
        end
        chk("block_done_count", ndone, 1);
        chk("block_acc", {8'd0, rn_a}, {8'd0, mac_ref(24'd10, 24'h010203, 24'd3, 1'b0)});
        arm = 4'd0;
        #1;
        chk("block_r0", {8'd0, rm_a}, 32'h1234);
        chk("block_idle", {31'd0, busy_a}, 0);

        // Start during DONE is ignored; the following cycle is accepted
        k = 24'h02FE01;
        p = 24'd7;
        a = 24'd1000;
        wr(4'd12, k);
        wr(4'd13, p);
        wr(4'd14, a);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(nb, seen);
        chk("b2b_first_done", {31'd0, seen}, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_ignored_in_done", {31'd0, busy_a}, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_restart", {31'd0, busy_a}, 1);
        wait_done(nb, seen);
        r1 = mac_ref(a, k, p, 1'b0);
        chk("b2b_second_done", {31'd0, seen}, 1);
        chk("b2b_acc", {8'd0, rn_a}, {8'd0, mac_ref(r1, k, p, 1'b0)});
        step();

        // Same-cycle KROW write with accepted start: MAC sees old, write commits
        wr(4'd12, 24'h010101);
        wr(4'd13, 24'd9);
        wr(4'd14, 24'd0);
        wen = 1'b1;
        ard = 4'd12;
        wdata = 24'h050505;
        start = 1'b1;
        step();
        wen = 1'b0;
        start = 1'b0;
        wait_done(nb, seen);
        chk("samecyc_acc", {8'd0, rn_a}, {8'd0, mac_ref(24'd0, 24'h010101, 24'd9, 1'b0)});
        arm = 4'd12;
        #1;
        chk("samecyc_krow", {8'd0, rm_a}, 32'h050505);
        step();

        // PC: architectural write wins for one cycle, then PC_DATA again
        wr(4'd15, 24'h000123);
        arm = 4'd15;
        #1;
        chk("pc_write", {8'd0, rm_a}, 32'h123);
        step();
        chk("pc_reload", {8'd0, rm_a}, 32'h40);

        // Reset in the middle of RUN
        wr(4'd12, 24'h010101);
        wr(4'd13, 24'd4);
        wr(4'd0, 24'h00ABCD);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            arn = 4'(i);
            #1;
            chk("midrst_reg", {8'd0, rn_a}, 0);
        end
        chk("midrst_busy", {31'd0, busy_a}, 0);
        chk("midrst_done", {31'd0, done_a}, 0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (done_a || busy_a) ndone++;
            step();
        end
        chk("midrst_no_done", ndone, 0);

        // Wide configuration: 32 regs, 32 bits, 4 elements
        wr_w(5'd28, 32'h01020304);
        wr_w(5'd29, 32'd1);
        wr_w(5'd30, 32'd0);
        w_arn = 5'd30;
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        nb = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (w_busy) nb++;
            if (w_done) seen = 1'b1;
            else step();
        end
        chk("wide_done_seen", {31'd0, seen}, 1);
        chk("wide_busy_cycles", nb, 4);
        chk("wide_acc", w_rn, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kernel_mac_register_file.md
# kernel_mac_register_file

Parametrised general-purpose register file with an integrated sequential kernel multiply-accumulate engine. It sits in the datapath memory stage and replaces the fixed 16×24 register file. Generalisations over the previous generation:
- register count and width are parameters;
- kernel element count per row word is a parameter;
- the convolution step is a multi-cycle FSM with a start/busy/done handshake instead of a per-write combinational update;
- accumulation can optionally saturate.

## Interface
Parameters:
- BITS, 24, register width; must be divisible by ELEMS.
- NUM_REGS, 16, register count; power of two, ≥ 8.
- ELEMS, 3, signed kernel elements packed per kernel-row word; EW = BITS/ELEMS bits each.
- SATURATE, 0, 0 = wrap-around accumulate, 1 = clamp to signed BITS range.

Ports (AW = $clog2(NUM_REGS)):
- CLK  in  1  single clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- WRT_ENA  in  1  architectural write enable.
- ADDRS_RD  in  AW  write address.
- ADDRS_RN, ADDRS_RM  in  AW  read addresses.
- WRT_DATA  in  BITS  write data.
- PC_DATA  in  BITS  next program counter, loaded into the PC register each cycle.
- MAC_START  in  1  start kernel-row MAC, sampled in IDLE only.
- RN_DATA, RM_DATA  out  BITS  combinational read data.
- MAC_BUSY  out  1  high in RUN.
- MAC_DONE  out  1  one-cycle completion pulse.

## Operation
- Dedicated indices: KROW = NUM_REGS-4 (kernel row), PIX = NUM_REGS-3 (pixel), ACC = NUM_REGS-2 (accumulator), PC = NUM_REGS-1.
- Reset: all registers 0, FSM IDLE, MAC_BUSY = 0, MAC_DONE = 0.
- Reads: combinational mux. A same-cycle write is not bypassed, so a read returns the old value.
- Writes: when WRT_ENA is set, register[ADDRS_RD] ← WRT_DATA on the clock edge.
- PC register: loads PC_DATA every cycle. An architectural write to PC takes priority for that cycle.
- FSM IDLE: MAC_START=1 latches KROW into an internal shift register and PIX into an operand register, clears element counter, → RUN.
- FSM RUN: each cycle, elem = signed top EW bits of shift register (most-significant element first).
  - ACC ← f(ACC + sext(elem)·PIX), with the full 2·BITS signed product.
  - f: SATURATE=0 truncates to BITS. SATURATE=1 clamps to [−2^(BITS−1), 2^(BITS−1)−1].
  - Shift register shifts left by EW and the counter increments.
  - After ELEMS steps → DONE.
- FSM DONE: MAC_DONE=1 for one cycle, → IDLE.
- During RUN/DONE:
  - architectural writes to KROW, PIX and ACC are dropped;
  - writes to other registers proceed;
  - MAC_START is ignored;
  - reads of ACC return the in-progress value.
- Zero element: the accumulator step still executes (adds 0) and the cycle count is unchanged.

## Timing
- MAC_START sampled at edge t. MAC_BUSY is high after edges t … t+ELEMS−1.
- ACC updates at edges t+1 … t+ELEMS.
- MAC_DONE is high for one cycle after edge t+ELEMS, with MAC_BUSY low. FSM is back in IDLE after edge t+ELEMS+1.
- Back-to-back: a MAC_START presented during DONE is ignored. The earliest accepted restart is the cycle after DONE.
- A write to KROW/PIX in the same cycle as an accepted MAC_START commits. The MAC uses the pre-write values.
- RST asserted mid-RUN: at the next edge all registers clear, FSM goes to IDLE, and no MAC_DONE is produced.

## Structure
- Package kmrf_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - index functions for KROW/PIX/ACC/PC given NUM_REGS;
  - signed saturation limit functions of BITS.
- Sub-module kmrf_mac_unit: combinational sext·multiply·add·optional saturate, parameterised by BITS, EW and SATURATE.
- The top module holds the register array, FSM, shift register and counter.

## Test plan
- Basic MAC (BITS=24, ELEMS=3, SATURATE=0): KROW=0x01FF02, PIX=100, ACC=0, pulse MAC_START. ACC = 100, 0, 200 on successive edges; MAC_DONE one cycle later; MAC_BUSY high exactly 3 cycles.
- Overflow: ACC=0x7FFFF0, KROW=0x010000, PIX=0x20.
  - SATURATE=0 gives ACC=0x800010.
  - SATURATE=1 gives ACC=0x7FFFFF.
  - Same for the negative case: ACC=0x800008, KROW=0xFF0000, PIX=0x10, SATURATE=1 → ACC=0x800000.
- Blocking: during RUN, write ACC=0x5555 and R0=0x1234, and assert MAC_START. ACC write is dropped, R0=0x1234, only one MAC_DONE is produced.
- PC: PC_DATA=0x000040 constant; write ADDRS_RD=15, WRT_DATA=0x000123. R15 reads 0x123 for one cycle, then 0x040.
- Reset mid-RUN: start the MAC, assert RST after 2 RUN cycles. Next cycle all reads return 0, MAC_BUSY=0, no MAC_DONE follows.
- Parameter sweep: NUM_REGS=32, BITS=32, ELEMS=4, KROW=0x01020304, PIX=1. ACC ends at 10 after 4 busy cycles; register 30 is ACC.
